// File: rtl/rpc_config_path_pkg.sv
// Shared types for the RPC configuration path.
// Command source encoding used by the arbiter and the CMD_FSM.
package rpc_config_path_pkg;

   typedef enum logic [1:0] {
      SRC_REF    = 2'd0,
      SRC_ZQC    = 2'd1,
      SRC_DIRECT = 2'd2
   } cmd_src_e;

endpackage

// File: rtl/rpc_cmd_arbiter.sv
// Refresh/ZQC/direct command arbiter with a single-entry output register.
// A starvation counter promotes a waiting direct command to top priority.
module rpc_cmd_arbiter
   import rpc_config_path_pkg::*;
#(
   parameter int CMD_WIDTH        = 19,
   parameter int STARVE_LIMIT     = 16,
   parameter int STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rpc_init_completed_i,
   input  logic                 ref_valid_i,
   input  logic [CMD_WIDTH-1:0] ref_cmd_i,
   output logic                 ref_ready_o,
   input  logic                 zqc_valid_i,
   input  logic [CMD_WIDTH-1:0] zqc_cmd_i,
   output logic                 zqc_ready_o,
   input  logic                 direct_cmd_valid_i,
   input  logic [CMD_WIDTH-1:0] direct_cmd_i,
   output logic                 direct_cmd_ready_o,
   output logic                 cmd_valid_o,
   output logic [CMD_WIDTH-1:0] cmd_o,
   input  logic                 cmd_ready_i,
   output cmd_src_e             cmd_src_o
);

   localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT =
      STARVE_CNT_WIDTH'(STARVE_LIMIT);

   logic                        cmd_valid_q;
   logic [CMD_WIDTH-1:0]        cmd_q;
   cmd_src_e                    src_q;
   logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;

   logic                 load_en;
   logic                 promote;
   logic                 gnt_ref, gnt_zqc, gnt_dir;
   logic                 xfer;
   logic [CMD_WIDTH-1:0] sel_cmd;
   cmd_src_e             sel_src;

   assign load_en = rpc_init_completed_i & (~cmd_valid_q | cmd_ready_i);
   assign promote = (starve_cnt_q == LIMIT);

   // Promotion only reorders direct ahead; ref > zqc holds otherwise.
   always_comb begin
      gnt_ref = 1'b0;
      gnt_zqc = 1'b0;
      gnt_dir = 1'b0;
      sel_cmd = direct_cmd_i;
      sel_src = SRC_DIRECT;
      if (promote && direct_cmd_valid_i) begin
         gnt_dir = 1'b1;
      end else if (ref_valid_i) begin
         gnt_ref = 1'b1;
         sel_cmd = ref_cmd_i;
         sel_src = SRC_REF;
      end else if (zqc_valid_i) begin
         gnt_zqc = 1'b1;
         sel_cmd = zqc_cmd_i;
         sel_src = SRC_ZQC;
      end else if (direct_cmd_valid_i) begin
         gnt_dir = 1'b1;
      end
   end

   assign ref_ready_o        = gnt_ref & load_en;
   assign zqc_ready_o        = gnt_zqc & load_en;
   assign direct_cmd_ready_o = gnt_dir & load_en;
   assign xfer = ref_ready_o | zqc_ready_o | direct_cmd_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         src_q       <= SRC_REF;
      end else if (xfer) begin
         cmd_valid_q <= 1'b1;
         cmd_q       <= sel_cmd;
         src_q       <= sel_src;
      end else if (cmd_ready_i) begin
         cmd_valid_q <= 1'b0;
      end
   end

   // Only lost arbitration counts; stalls and init-gating hold the count.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (direct_cmd_ready_o) begin
         starve_cnt_d = '0;
      end else if (direct_cmd_valid_i && xfer && !promote) begin
         starve_cnt_d = starve_cnt_q + STARVE_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign cmd_valid_o = cmd_valid_q;
   assign cmd_o       = cmd_q;
   assign cmd_src_o   = src_q;

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Scoreboard bench for rpc_cmd_arbiter.
// Expected outputs are queued by each scenario and popped on every accept.
module tb_rpc_cmd_arbiter;
   import rpc_config_path_pkg::*;

   localparam int W = 19;

   typedef struct {
      logic [W-1:0] cmd;
      logic [1:0]   src;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         init = 1'b0;
   logic         ref_valid = 1'b0, zqc_valid = 1'b0, dir_valid = 1'b0;
   logic [W-1:0] ref_cmd = '0, zqc_cmd = '0, dir_cmd = '0;
   logic         ref_ready, zqc_ready, dir_ready;
   logic         cmd_valid, cmd_ready = 1'b0;
   logic [W-1:0] cmd;
   cmd_src_e     cmd_src;
   logic         ref_cont = 1'b0;
   logic         mon_en = 1'b1;

   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   rpc_cmd_arbiter #(
      .CMD_WIDTH(W),
      .STARVE_LIMIT(4)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .rpc_init_completed_i(init),
      .ref_valid_i(ref_valid),
      .ref_cmd_i(ref_cmd),
      .ref_ready_o(ref_ready),
      .zqc_valid_i(zqc_valid),
      .zqc_cmd_i(zqc_cmd),
      .zqc_ready_o(zqc_ready),
      .direct_cmd_valid_i(dir_valid),
      .direct_cmd_i(dir_cmd),
      .direct_cmd_ready_o(dir_ready),
      .cmd_valid_o(cmd_valid),
      .cmd_o(cmd),
      .cmd_ready_i(cmd_ready),
      .cmd_src_o(cmd_src)
   );

   always @(negedge clk) begin
      if (mon_en && rst_n && cmd_valid && cmd_ready) begin
         exp_t e;
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL out_unexpected got cmd=%h src=%0d want none",
                     cmd, cmd_src);
         end else begin
            e = exp_q.pop_front();
            if (cmd !== e.cmd || cmd_src !== e.src) begin
               fails = fails + 1;
               $display("FAIL out_order got cmd=%h src=%0d want cmd=%h src=%0d",
                        cmd, cmd_src, e.cmd, e.src);
            end
         end
      end
   end

   function automatic void push(input logic [W-1:0] c, input logic [1:0] s);
      exp_t e;
      e.cmd = c;
      e.src = s;
      exp_q.push_back(e);
   endfunction

   // Called at a negedge: records handshakes, then advances to posedge+1.
   task automatic step();
      logic r, z, d;
      r = ref_valid & ref_ready;
      z = zqc_valid & zqc_ready;
      d = dir_valid & dir_ready;
      @(posedge clk);
      #1;
      if (r) begin
         if (ref_cont) ref_cmd = ref_cmd + 1;
         else ref_valid = 1'b0;
      end
      if (z) zqc_valid = 1'b0;
      if (d) dir_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests = tests + 1;
      if (cmd_valid !== 1'b0 || cmd !== '0 || cmd_src !== SRC_REF) begin
         fails = fails + 1;
         $display("FAIL reset_state got v=%b cmd=%h src=%0d want 0/0/0",
                  cmd_valid, cmd, cmd_src);
      end
      tests = tests + 1;
      if ({ref_ready, zqc_ready, dir_ready} !== 3'b000) begin
         fails = fails + 1;
         $display("FAIL reset_ready got %b want 000",
                  {ref_ready, zqc_ready, dir_ready});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_init_gate();
      ref_valid = 1'b1; ref_cmd = 19'h7;
      zqc_valid = 1'b1; zqc_cmd = 19'h8;
      dir_valid = 1'b1; dir_cmd = 19'h9;
      cmd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if ({ref_ready, zqc_ready, dir_ready, cmd_valid} !== 4'b0000) begin
            fails = fails + 1;
            $display("FAIL init_gate cyc %0d got rdy=%b v=%b want 000/0", i,
                     {ref_ready, zqc_ready, dir_ready}, cmd_valid);
         end
         step();
      end
      ref_valid = 1'b0;
      zqc_valid = 1'b0;
      dir_valid = 1'b0;
   endtask

   task automatic test_priority();
      logic [2:0]   rdy [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
      logic [W-1:0] oc  [4] = '{19'h0, 19'h1, 19'h2, 19'h3};
      init = 1'b1;
      cmd_ready = 1'b1;
      ref_cont = 1'b0;
      ref_valid = 1'b1; ref_cmd = 19'h1;
      zqc_valid = 1'b1; zqc_cmd = 19'h2;
      dir_valid = 1'b1; dir_cmd = 19'h3;
      push(19'h1, 2'd0);
      push(19'h2, 2'd1);
      push(19'h3, 2'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if ({ref_ready, zqc_ready, dir_ready} !== rdy[i]) begin
            fails = fails + 1;
            $display("FAIL prio_ready cyc %0d got %b want %b", i,
                     {ref_ready, zqc_ready, dir_ready}, rdy[i]);
         end
         if (i > 0) begin
            tests = tests + 1;
            if (cmd_valid !== 1'b1 || cmd !== oc[i]) begin
               fails = fails + 1;
               $display("FAIL prio_latency cyc %0d got v=%b cmd=%h want 1/%h",
                        i, cmd_valid, cmd, oc[i]);
            end
         end
         step();
      end
      @(negedge clk);
      tests = tests + 1;
      if (cmd_valid !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL prio_empty got v=%b want 0", cmd_valid);
      end
      step();
   endtask

   task automatic test_stall();
      logic [2:0] rdy [5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
      cmd_ready = 1'b0;
      ref_cont = 1'b1;
      ref_valid = 1'b1; ref_cmd = 19'h11;
      dir_valid = 1'b1; dir_cmd = 19'h22;
      push(19'h11, 2'd0);
      @(negedge clk);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if (cmd_valid !== 1'b1 || cmd !== 19'h11 ||
             {ref_ready, zqc_ready, dir_ready} !== 3'b000) begin
            fails = fails + 1;
            $display("FAIL stall_hold cyc %0d got v=%b cmd=%h rdy=%b want 1/11/000",
                     i, cmd_valid, cmd, {ref_ready, zqc_ready, dir_ready});
         end
         step();
      end
      cmd_ready = 1'b1;
      push(19'h12, 2'd0);
      push(19'h13, 2'd0);
      push(19'h14, 2'd0);
      push(19'h22, 2'd2);
      push(19'h15, 2'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if ({ref_ready, zqc_ready, dir_ready} !== rdy[i]) begin
            fails = fails + 1;
            $display("FAIL stall_resume cyc %0d got %b want %b", i,
                     {ref_ready, zqc_ready, dir_ready}, rdy[i]);
         end
         step();
      end
      ref_valid = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      step();
   endtask

   task automatic test_starvation();
      logic [2:0] rdy [10];
      for (int i = 0; i < 10; i++) begin
         rdy[i] = (i == 4 || i == 9) ? 3'b001 : 3'b100;
      end
      ref_cont = 1'b1;
      ref_valid = 1'b1; ref_cmd = 19'h40;
      dir_valid = 1'b1; dir_cmd = 19'h50;
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(19'h40 + 19'(i), 2'd0);
      push(19'h50, 2'd2);
      for (int i = 4; i < 8; i++) push(19'h40 + 19'(i), 2'd0);
      push(19'h51, 2'd2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if ({ref_ready, zqc_ready, dir_ready} !== rdy[i]) begin
            fails = fails + 1;
            $display("FAIL starve_grant cyc %0d got %b want %b", i,
                     {ref_ready, zqc_ready, dir_ready}, rdy[i]);
         end
         step();
         if (i == 4) begin
            dir_valid = 1'b1;
            dir_cmd = 19'h51;
         end
      end
      ref_valid = 1'b0;
      dir_valid = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      step();
   endtask

   task automatic test_init_drop();
      ref_cont = 1'b0;
      cmd_ready = 1'b0;
      ref_valid = 1'b1; ref_cmd = 19'h60;
      push(19'h60, 2'd0);
      @(negedge clk);
      step();
      init = 1'b0;
      ref_valid = 1'b1; ref_cmd = 19'h61;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if (cmd_valid !== 1'b1 || cmd !== 19'h60 || ref_ready !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL initdrop_hold cyc %0d got v=%b cmd=%h rr=%b want 1/60/0",
                     i, cmd_valid, cmd, ref_ready);
         end
         step();
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      tests = tests + 1;
      if (ref_ready !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL initdrop_drain got rr=%b want 0", ref_ready);
      end
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests = tests + 1;
         if (cmd_valid !== 1'b0 || ref_ready !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL initdrop_noload cyc %0d got v=%b rr=%b want 0/0",
                     i, cmd_valid, ref_ready);
         end
         step();
      end
      init = 1'b1;
      push(19'h61, 2'd0);
      @(negedge clk);
      tests = tests + 1;
      if (ref_ready !== 1'b1) begin
         fails = fails + 1;
         $display("FAIL initdrop_resume got rr=%b want 1", ref_ready);
      end
      step();
      @(negedge clk);
      step();
   endtask

   task automatic test_reset_mid();
      ref_cont = 1'b1;
      ref_valid = 1'b1; ref_cmd = 19'h70;
      cmd_ready = 1'b1;
      push(19'h70, 2'd0);
      @(negedge clk);
      step();
      @(negedge clk);
      step();
      ref_valid = 1'b0;
      ref_cont = 1'b0;
      rst_n = 1'b0;
      init = 1'b0;
      #1;
      tests = tests + 1;
      if (cmd_valid !== 1'b0 || cmd !== '0 || cmd_src !== SRC_REF) begin
         fails = fails + 1;
         $display("FAIL reset_mid got v=%b cmd=%h src=%0d want 0/0/0",
                  cmd_valid, cmd, cmd_src);
      end
      @(posedge clk);
      #1;
      tests = tests + 1;
      if (cmd_valid !== 1'b0 || cmd !== '0 || ref_ready !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL reset_mid_edge got v=%b cmd=%h rr=%b want 0/0/0",
                  cmd_valid, cmd, ref_ready);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_init_gate();
      test_priority();
      test_stall();
      test_starvation();
      test_init_drop();
      test_reset_mid();
      tests = tests + 1;
      if (exp_q.size() != 0) begin
         fails = fails + 1;
         $display("FAIL scoreboard_left got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
